// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing constants
// and the frame parity helper used by the host-side PS/2 blocks.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_CLK,
        SEND_BITS,
        WAIT_ACK,
        WAIT_RELEASE
    } ps2_state_e;

    // 100us request hold and 2ms watchdog at a 50MHz system clock
    localparam int PS2_HOLD_CYCLES    = 5000;
    localparam int PS2_TIMEOUT_CYCLES = 100000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/mouse_transmitter_if.sv
// Command handshake plus PS/2 pad signals between the mouse master
// state machine, the transmitter and the open-drain pad logic.
interface mouse_transmitter_if;

    logic       CLK_MOUSE_IN;
    logic       CLK_MOUSE_OUT_EN;
    logic       DATA_MOUSE_IN;
    logic       DATA_MOUSE_OUT;
    logic       DATA_MOUSE_OUT_EN;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;

    modport slave (
        input  CLK_MOUSE_IN,
        input  DATA_MOUSE_IN,
        input  SEND_BYTE,
        input  BYTE_TO_SEND,
        output CLK_MOUSE_OUT_EN,
        output DATA_MOUSE_OUT,
        output DATA_MOUSE_OUT_EN,
        output BYTE_SENT
    );

    modport master (
        output CLK_MOUSE_IN,
        output DATA_MOUSE_IN,
        output SEND_BYTE,
        output BYTE_TO_SEND,
        input  CLK_MOUSE_OUT_EN,
        input  DATA_MOUSE_OUT,
        input  DATA_MOUSE_OUT_EN,
        input  BYTE_SENT
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pads, plus
// registered falling-edge and any-edge pulses on the synced clock.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o,
    output logic clk_edge_o
);

    // [1:0] is the synchroniser, [2] holds the previous synced value
    logic [2:0] clk_sh_q;
    logic [1:0] dat_sh_q;
    logic       fall_q;
    logic       edge_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sh_q <= '1;
            dat_sh_q <= '1;
            fall_q   <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            clk_sh_q <= {clk_sh_q[1:0], ps2_clk_i};
            dat_sh_q <= {dat_sh_q[0], ps2_data_i};
            fall_q   <= clk_sh_q[2] & ~clk_sh_q[1];
            edge_q   <= clk_sh_q[2] ^ clk_sh_q[1];
        end
    end

    assign clk_sync_o  = clk_sh_q[1];
    assign data_sync_o = dat_sh_q[1];
    assign clk_fall_o  = fall_q;
    assign clk_edge_o  = edge_q;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: clock-hold request, start bit, 8 data
// bits LSB first, odd parity, stop by release, then device ACK.
module mouse_transmitter
    import ps2_pkg::*;
#(
    parameter int CLK_HOLD_CYCLES = PS2_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES  = PS2_TIMEOUT_CYCLES
) (
    input  logic CLK,
    input  logic RESET,
    mouse_transmitter_if.slave bus
);

    localparam int MAXC = (CLK_HOLD_CYCLES > TIMEOUT_CYCLES) ?
                          CLK_HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CLK_HOLD_CYCLES);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    logic clk_s;
    logic data_s;
    logic clk_fall;
    logic clk_edge;

    ps2_line_sync u_sync (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .ps2_clk_i  (bus.CLK_MOUSE_IN),
        .ps2_data_i (bus.DATA_MOUSE_IN),
        .clk_sync_o (clk_s),
        .data_sync_o(data_s),
        .clk_fall_o (clk_fall),
        .clk_edge_o (clk_edge)
    );

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic          clk_en_q, clk_en_d;
    logic          dat_q, dat_d;
    logic          dat_en_q, dat_en_d;
    logic          sent_q, sent_d;

    logic watched;
    logic wd_fire;

    assign watched = (state_q == SEND_BITS) || (state_q == WAIT_ACK) ||
                     (state_q == WAIT_RELEASE);
    assign wd_fire = !clk_edge && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        par_d    = par_q;
        clk_en_d = clk_en_q;
        dat_d    = dat_q;
        dat_en_d = dat_en_q;
        sent_d   = sent_q;

        unique case (state_q)
            IDLE: begin
                clk_en_d = 1'b0;
                dat_en_d = 1'b0;
                dat_d    = 1'b1;
                if (bus.SEND_BYTE) begin
                    sent_d = 1'b0;
                    // a low data line means the device is talking
                    if (data_s) begin
                        byte_d   = bus.BYTE_TO_SEND;
                        par_d    = odd_parity(bus.BYTE_TO_SEND);
                        cnt_d    = '0;
                        clk_en_d = 1'b1;
                        state_d  = HOLD_CLK;
                    end
                end
            end
            HOLD_CLK: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HOLD_LAST) begin
                    dat_en_d = 1'b1;
                    dat_d    = 1'b0;
                end
                if (cnt_q == HOLD_END) begin
                    clk_en_d = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = SEND_BITS;
                end
            end
            SEND_BITS: begin
                cnt_d = clk_edge ? '0 : cnt_q + CW'(1);
                if (clk_fall) begin
                    bit_d = bit_q + 4'd1;
                    unique case (1'b1)
                        bit_q < 4'd8:  dat_d = byte_q[bit_q[2:0]];
                        bit_q == 4'd8: dat_d = par_q;
                        default: begin
                            dat_d    = 1'b1;
                            dat_en_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = WAIT_ACK;
                        end
                    endcase
                end
            end
            WAIT_ACK: begin
                cnt_d = clk_edge ? '0 : cnt_q + CW'(1);
                if (clk_fall && !data_s) begin
                    cnt_d   = '0;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                cnt_d = clk_edge ? '0 : cnt_q + CW'(1);
                if (clk_s && data_s) begin
                    sent_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // watchdog abort wins over any same-cycle progress
        if (watched && wd_fire) begin
            clk_en_d = 1'b0;
            dat_en_d = 1'b0;
            dat_d    = 1'b1;
            sent_d   = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            par_q    <= 1'b0;
            clk_en_q <= 1'b0;
            dat_q    <= 1'b1;
            dat_en_q <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            par_q    <= par_d;
            clk_en_q <= clk_en_d;
            dat_q    <= dat_d;
            dat_en_q <= dat_en_d;
            sent_q   <= sent_d;
        end
    end

    assign bus.CLK_MOUSE_OUT_EN  = clk_en_q;
    assign bus.DATA_MOUSE_OUT    = dat_q;
    assign bus.DATA_MOUSE_OUT_EN = dat_en_q;
    assign bus.BYTE_SENT         = sent_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: a PS/2 device model on wired-AND lines,
// frame contents predicted from byte arithmetic and checked every cycle.
module tb_mouse_transmitter;

    localparam int HOLD = 4;
    localparam int TO   = 2000;

    logic CLK      = 1'b0;
    logic RESET    = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    mouse_transmitter_if bus ();

    // open-drain lines: either side may pull low
    assign bus.CLK_MOUSE_IN  = dev_clk & ~bus.CLK_MOUSE_OUT_EN;
    assign bus.DATA_MOUSE_IN = dev_data &
                               ~(bus.DATA_MOUSE_OUT_EN & ~bus.DATA_MOUSE_OUT);

    mouse_transmitter #(
        .CLK_HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #10 CLK = ~CLK;

    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   sent_at = 0;
    bit   exp_sent  = 1'b0;
    bit   exp_quiet = 1'b1;
    logic [8:0] got;
    logic [7:0] rb;

    function automatic bit model_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // {enable, value} on the data line after device falling edge k
    function automatic logic [1:0] model_line(input logic [7:0] b,
                                              input int k);
        if (k <= 8) return {1'b1, b[k-1]};
        if (k == 9) return {1'b1, model_par(b)};
        return 2'b01;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: invariant checks on the falling edge, then drive point
    task automatic step();
        @(negedge CLK);
        cyc++;
        if (cyc >= sent_at) chk("byte_sent_level", bus.BYTE_SENT, exp_sent);
        if (exp_quiet) begin
            chk("quiet_clk_en", bus.CLK_MOUSE_OUT_EN, 0);
            chk("quiet_data_en", bus.DATA_MOUSE_OUT_EN, 0);
        end
        if (!bus.DATA_MOUSE_OUT_EN)
            chk("released_data_high", bus.DATA_MOUSE_OUT, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b, input bit accept);
        bus.BYTE_TO_SEND = b;
        bus.SEND_BYTE    = 1'b1;
        if (accept) exp_quiet = 1'b0;
        step();
        bus.SEND_BYTE    = 1'b0;
        bus.BYTE_TO_SEND = 8'($urandom);
        exp_sent = 1'b0;
        sent_at  = cyc;
    endtask

    task automatic start_frame(input logic [7:0] b);
        int n;
        send(b, 1'b1);
        n = 0;
        while (bus.CLK_MOUSE_OUT_EN && n < 50) begin
            n++;
            step();
        end
        chk("hold_len", 16'(n), 16'(HOLD + 1));
        chk("start_bit", {bus.DATA_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT}, 2'b10);
    endtask

    task automatic clock_bits(input logic [7:0] b, input int np,
                              output logic [8:0] bits);
        bits = '0;
        steps($urandom_range(2, 10));
        for (int k = 1; k <= np; k++) begin
            dev_clk = 1'b0;
            steps($urandom_range(8, 16));
            chk($sformatf("edge%0d_line", k),
                {bus.DATA_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT}, model_line(b, k));
            if (k <= 9) bits[k-1] = bus.DATA_MOUSE_OUT;
            if (k >= 10) exp_quiet = 1'b1;
            dev_clk = 1'b1;
            steps($urandom_range(8, 16));
        end
    endtask

    task automatic ack();
        dev_data = 1'b0;
        steps(3);
        dev_clk = 1'b0;
        steps(10);
        dev_clk = 1'b1;
        steps(4);
        dev_data = 1'b1;
        exp_sent = 1'b1;
        sent_at  = cyc + 10;
        steps(12);
        chk("byte_sent_after_ack", bus.BYTE_SENT, 1);
    endtask

    task automatic expect_abort(input string nm);
        chk({nm, "_clk_en"}, bus.CLK_MOUSE_OUT_EN, 0);
        chk({nm, "_data_en"}, bus.DATA_MOUSE_OUT_EN, 0);
        chk({nm, "_data"}, bus.DATA_MOUSE_OUT, 1);
        chk({nm, "_sent"}, bus.BYTE_SENT, 0);
        exp_quiet = 1'b1;
    endtask

    task automatic glitch();
        step();
        #($urandom_range(12, 18));
        dev_clk = 1'b0;
        #5;
        dev_clk = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic full_frame(input logic [7:0] b, input string nm);
        start_frame(b);
        clock_bits(b, 10, got);
        chk({nm, "_bits"}, 16'(got), 16'({model_par(b), b}));
        ack();
    endtask

    initial begin
        bus.SEND_BYTE    = 1'b0;
        bus.BYTE_TO_SEND = 8'h00;
        #2 RESET = 1'b1;
        #1;
        chk("rst_clk_en", bus.CLK_MOUSE_OUT_EN, 0);
        chk("rst_data", bus.DATA_MOUSE_OUT, 1);
        chk("rst_data_en", bus.DATA_MOUSE_OUT_EN, 0);
        chk("rst_sent", bus.BYTE_SENT, 0);
        steps(3);
        RESET = 1'b0;
        steps(5);

        // 0xAA pinned by hand: bits 0,1,0,1,0,1,0,1 and parity 1
        start_frame(8'hAA);
        clock_bits(8'hAA, 10, got);
        chk("aa_bits_literal", 16'(got), 16'h01AA);
        ack();

        // device holds data low: request rejected, sent flag cleared
        dev_data = 1'b0;
        steps(4);
        send(8'hCC, 1'b0);
        steps(20);
        chk("reject_sent", bus.BYTE_SENT, 0);
        chk("reject_clk_en", bus.CLK_MOUSE_OUT_EN, 0);
        dev_data = 1'b1;
        steps(4);

        // underflow: five clocks, then watchdog
        start_frame(8'hF0);
        clock_bits(8'hF0, 5, got);
        steps(1800);
        chk("f0_driving_before_timeout", bus.DATA_MOUSE_OUT_EN, 1);
        steps(300);
        expect_abort("f0_timeout");

        // overflow: twelve clocks, no ACK
        start_frame(8'h55);
        clock_bits(8'h55, 12, got);
        chk("55_bits", 16'(got), 16'({model_par(8'h55), 8'h55}));
        steps(2100);
        expect_abort("55_timeout");

        // short glitches on the clock line only
        start_frame(8'h33);
        for (int i = 0; i < 10; i++) begin
            glitch();
            steps(20);
        end
        steps(2100);
        expect_abort("33_glitch");

        // back-to-back frames
        full_frame(8'hA5, "a5");
        start_frame(8'h5A);
        chk("b2b_cleared", bus.BYTE_SENT, 0);
        clock_bits(8'h5A, 10, got);
        chk("5a_bits", 16'(got), 16'({model_par(8'h5A), 8'h5A}));
        ack();

        // both extremes carry parity 1
        start_frame(8'h00);
        clock_bits(8'h00, 10, got);
        chk("00_parity_literal", got[8], 1);
        ack();
        start_frame(8'hFF);
        clock_bits(8'hFF, 10, got);
        chk("ff_parity_literal", got[8], 1);
        ack();

        repeat (8) begin
            rb = 8'($urandom);
            full_frame(rb, $sformatf("rand_%02h", rb));
        end

        // asynchronous reset in the middle of the data bits
        start_frame(8'h3C);
        clock_bits(8'h3C, 4, got);
        #4 RESET = 1'b1;
        #1;
        chk("midrst_clk_en", bus.CLK_MOUSE_OUT_EN, 0);
        chk("midrst_data_en", bus.DATA_MOUSE_OUT_EN, 0);
        chk("midrst_sent", bus.BYTE_SENT, 0);
        exp_quiet = 1'b1;
        steps(3);
        RESET = 1'b0;
        steps(3);
        full_frame(8'hC3, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
